mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_arb_pkg.sv | 43 ++++
 rtl/mem_arb_rr_pick.sv | 16 +
 rtl/mem_port_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the two-requester memory
// port arbiter.
//   arb_state_e : arbiter FSM states (IDLE / ISSUE / BUSY)
//   cmd_e       : command kind latched at grant
//   BEATS_*     : m_ready beats expected per command kind
//   pick_cmd    : resolves several command bits from one requester
//   last_beat   : beat-counter value of the final beat for a command
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2
  } arb_state_e;

  typedef enum logic [2:0] {
    CMD_NONE    = 3'd0,
    CMD_RD_WORD = 3'd1,
    CMD_RD_LINE = 3'd2,
    CMD_WR_WORD = 3'd3,
    CMD_WR_LINE = 3'd4
  } cmd_e;

  localparam int BEATS_LINE_RD = 4;
  localparam int BEATS_OTHER   = 1;

  // Within one requester: read word > read line > word write > line write.
  function automatic cmd_e pick_cmd(input logic rd_word, input logic rd_line,
                                    input logic wr_word, input logic wr_line);
    if (rd_word)      return CMD_RD_WORD;
    else if (rd_line) return CMD_RD_LINE;
    else if (wr_word) return CMD_WR_WORD;
    else if (wr_line) return CMD_WR_LINE;
    else              return CMD_NONE;
  endfunction

  // Beat counter starts at 0, so the final beat is at BEATS-1.
  function automatic logic [1:0] last_beat(input cmd_e cmd);
    if (cmd == CMD_RD_LINE) return 2'(BEATS_LINE_RD - 1);
    else                    return 2'(BEATS_OTHER - 1);
  endfunction

endpackage

// File: rtl/mem_arb_rr_pick.sv
// mem_arb_rr_pick: 2-way round-robin picker (combinational).
//   req : request bits, one per requester
//   ptr : index of the requester favoured on a tie
//   gnt : one-hot winner, 2'b00 when nothing requests
module mem_arb_rr_pick (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);

  always_comb begin
    gnt[0] = req[0] & (~req[1] | ~ptr);
    gnt[1] = req[1] & (~req[0] |  ptr);
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory data port between two requesters.
// A winner is chosen in IDLE, its command is pulsed (reads) or held
// (writes) from ISSUE, and m_ready beats are forwarded to the owner
// during BUSY until the final beat (4 for a line read, 1 otherwise).
//
// Ports
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   rq_*                  : packed per-requester inputs (requester n in slice n)
//   rq_ready, rq_grant    : per-requester beat strobe / one-hot owner
//   rq_data_out(_offset)  : read data broadcast from the memory
//   m_*  (outputs)        : command/address/data to the memory
//   m_data_out(_offset), m_ready : memory responses
//
// Build option: define MEM_ARB_FIXED_PRIO_EN to make requester 0 always
// win a tie instead of round-robin.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [2*(ADDR_WIDTH+2)-1:0]   rq_address,
  input  logic [255:0]                  rq_data_in,
  input  logic [7:0]                    rq_word_in_be,
  input  logic [1:0]                    rq_read_word,
  input  logic [1:0]                    rq_read_line,
  input  logic [1:0]                    rq_word_in_ready,
  input  logic [1:0]                    rq_line_in_ready,
  output logic [1:0]                    rq_ready,
  output logic [1:0]                    rq_grant,
  output logic [31:0]                   rq_data_out,
  output logic [1:0]                    rq_data_out_offset,
  output logic [ADDR_WIDTH+1:0]         m_address,
  output logic [127:0]                  m_data_in,
  output logic [3:0]                    m_word_in_be,
  output logic                          m_read_word,
  output logic                          m_read_line,
  output logic                          m_word_in_ready,
  output logic                          m_line_in_ready,
  input  logic [31:0]                   m_data_out,
  input  logic [1:0]                    m_data_out_offset,
  input  logic                          m_ready
);

  localparam int AW = ADDR_WIDTH + 2;

  arb_state_e state_q, state_d;
  cmd_e       cmd_q, cmd_d;
  logic [1:0] grant_q, grant_d;
  logic [1:0] beat_q, beat_d;
  logic       ptr_q, ptr_d;
  logic       rd_word_q, rd_word_d;
  logic       rd_line_q, rd_line_d;
  logic       wr_word_q, wr_word_d;
  logic       wr_line_q, wr_line_d;

  logic [1:0] req;
  logic [1:0] pick;
  logic       pick_ptr;
  cmd_e       cmd0, cmd1, win_cmd;

  assign req[0] = rq_read_word[0] | rq_read_line[0] | rq_word_in_ready[0] | rq_line_in_ready[0];
  assign req[1] = rq_read_word[1] | rq_read_line[1] | rq_word_in_ready[1] | rq_line_in_ready[1];

  assign cmd0 = pick_cmd(rq_read_word[0], rq_read_line[0], rq_word_in_ready[0], rq_line_in_ready[0]);
  assign cmd1 = pick_cmd(rq_read_word[1], rq_read_line[1], rq_word_in_ready[1], rq_line_in_ready[1]);
  assign win_cmd = pick[1] ? cmd1 : cmd0;

`ifdef MEM_ARB_FIXED_PRIO_EN
  assign pick_ptr = 1'b0;
`else
  assign pick_ptr = ptr_q;
`endif

  mem_arb_rr_pick u_pick (
    .req (req),
    .ptr (pick_ptr),
    .gnt (pick)
  );

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    grant_d   = grant_q;
    beat_d    = beat_q;
    ptr_d     = ptr_q;
    rd_word_d = rd_word_q;
    rd_line_d = rd_line_q;
    wr_word_d = wr_word_q;
    wr_line_d = wr_line_q;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d   = ST_ISSUE;
          grant_d   = pick;
          cmd_d     = win_cmd;
          beat_d    = 2'd0;
          rd_word_d = (win_cmd == CMD_RD_WORD);
          rd_line_d = (win_cmd == CMD_RD_LINE);
          wr_word_d = (win_cmd == CMD_WR_WORD);
          wr_line_d = (win_cmd == CMD_WR_LINE);
        end
      end
      ST_ISSUE: begin
        // Read strobes last exactly one cycle; m_ready here is ignored.
        state_d   = ST_BUSY;
        rd_word_d = 1'b0;
        rd_line_d = 1'b0;
      end
      ST_BUSY: begin
        if (m_ready) begin
          if (beat_q == last_beat(cmd_q)) begin
            state_d   = ST_IDLE;
            grant_d   = 2'b00;
            cmd_d     = CMD_NONE;
            beat_d    = 2'd0;
            wr_word_d = 1'b0;
            wr_line_d = 1'b0;
            // Favour whoever was not just served.
            ptr_d     = ~grant_q[1];
          end else begin
            beat_d = beat_q + 2'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cmd_q     <= CMD_NONE;
      grant_q   <= 2'b00;
      beat_q    <= 2'd0;
      ptr_q     <= 1'b0;
      rd_word_q <= 1'b0;
      rd_line_q <= 1'b0;
      wr_word_q <= 1'b0;
      wr_line_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      grant_q   <= grant_d;
      beat_q    <= beat_d;
      ptr_q     <= ptr_d;
      rd_word_q <= rd_word_d;
      rd_line_q <= rd_line_d;
      wr_word_q <= wr_word_d;
      wr_line_q <= wr_line_d;
    end
  end

  // grant_q is zero in IDLE, so the data path falls to zeros there.
  always_comb begin
    m_address    = '0;
    m_data_in    = '0;
    m_word_in_be = '0;
    if (grant_q[0]) begin
      m_address    = rq_address[0 +: AW];
      m_data_in    = rq_data_in[0 +: 128];
      m_word_in_be = rq_word_in_be[0 +: 4];
    end else if (grant_q[1]) begin
      m_address    = rq_address[AW +: AW];
      m_data_in    = rq_data_in[128 +: 128];
      m_word_in_be = rq_word_in_be[4 +: 4];
    end
  end

  // Gated by reset so a beat arriving in the reset cycle is not forwarded.
  assign rq_ready = (state_q == ST_BUSY && !reset) ? ({2{m_ready}} & grant_q) : 2'b00;
  assign rq_grant = grant_q;

  assign rq_data_out        = m_data_out;
  assign rq_data_out_offset = m_data_out_offset;

  assign m_read_word     = rd_word_q;
  assign m_read_line     = rd_line_q;
  assign m_word_in_ready = wr_word_q;
  assign m_line_in_ready = wr_line_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter.
// Inputs change and outputs are sampled around the falling clock edge;
// the memory side (m_ready, m_data_out) is driven by hand per step.
// Prints one summary line: *** SUMMARY: <compared> compared / <mismatched> mismatched ***
module tb_mem_port_arbiter;

  localparam int ADDR_WIDTH = 12;
  localparam int AW = ADDR_WIDTH + 2;

  logic               clock = 1'b0;
  logic               reset;
  logic [2*AW-1:0]    rq_address;
  logic [255:0]       rq_data_in;
  logic [7:0]         rq_word_in_be;
  logic [1:0]         rq_read_word, rq_read_line, rq_word_in_ready, rq_line_in_ready;
  logic [1:0]         rq_ready, rq_grant;
  logic [31:0]        rq_data_out;
  logic [1:0]         rq_data_out_offset;
  logic [AW-1:0]      m_address;
  logic [127:0]       m_data_in;
  logic [3:0]         m_word_in_be;
  logic               m_read_word, m_read_line, m_word_in_ready, m_line_in_ready;
  logic [31:0]        m_data_out;
  logic [1:0]         m_data_out_offset;
  logic               m_ready;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  mem_port_arbiter #(.ADDR_WIDTH(ADDR_WIDTH)) dut (
    .clock              (clock),
    .reset              (reset),
    .rq_address         (rq_address),
    .rq_data_in         (rq_data_in),
    .rq_word_in_be      (rq_word_in_be),
    .rq_read_word       (rq_read_word),
    .rq_read_line       (rq_read_line),
    .rq_word_in_ready   (rq_word_in_ready),
    .rq_line_in_ready   (rq_line_in_ready),
    .rq_ready           (rq_ready),
    .rq_grant           (rq_grant),
    .rq_data_out        (rq_data_out),
    .rq_data_out_offset (rq_data_out_offset),
    .m_address          (m_address),
    .m_data_in          (m_data_in),
    .m_word_in_be       (m_word_in_be),
    .m_read_word        (m_read_word),
    .m_read_line        (m_read_line),
    .m_word_in_ready    (m_word_in_ready),
    .m_line_in_ready    (m_line_in_ready),
    .m_data_out         (m_data_out),
    .m_data_out_offset  (m_data_out_offset),
    .m_ready            (m_ready)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; returns just after the falling edge, then settles.
  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  // One memory beat in BUSY: drive m_ready with offset n, check forwarding.
  task automatic beat(input string tag, input int n, input logic [1:0] exp_rdy);
    m_ready = 1'b1;
    m_data_out_offset = 2'(n);
    m_data_out = 32'hD000_0000 + 32'(n);
    #1;
    check({tag, ".rdy"}, 128'(rq_ready), 128'(exp_rdy));
    check({tag, ".off"}, 128'(rq_data_out_offset), 128'(n));
    check({tag, ".dat"}, 128'(rq_data_out), 128'(32'hD000_0000 + 32'(n)));
    tick();
    m_ready = 1'b0;
  endtask

  task automatic clear_inputs();
    rq_address = '0; rq_data_in = '0; rq_word_in_be = '0;
    rq_read_word = '0; rq_read_line = '0; rq_word_in_ready = '0; rq_line_in_ready = '0;
    m_data_out = '0; m_data_out_offset = '0; m_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    int exp_idx;
    clear_inputs();
    do_reset();

    // Reset state
    check("rst.grant", 128'(rq_grant), 128'(2'b00));
    check("rst.ready", 128'(rq_ready), 128'(2'b00));
    check("rst.cmds", 128'({m_read_word, m_read_line, m_word_in_ready, m_line_in_ready}), 128'(4'b0000));
    check("rst.addr", 128'(m_address), 128'(0));

    // Line read by requester 0 at 0x0040
    rq_read_line = 2'b01;
    rq_address[0 +: AW] = 14'h0040;
    tick();
    check("rl.issue.grant", 128'(rq_grant), 128'(2'b01));
    check("rl.issue.rdline", 128'(m_read_line), 128'(1));
    check("rl.issue.addr", 128'(m_address), 128'(14'h0040));
    m_ready = 1'b1;  // ignored in ISSUE
    #1;
    check("rl.issue.ignore", 128'(rq_ready), 128'(2'b00));
    tick();
    m_ready = 1'b0;
    #1;
    check("rl.busy.rdline", 128'(m_read_line), 128'(0));
    check("rl.busy.grant", 128'(rq_grant), 128'(2'b01));
    for (int i = 0; i < 4; i++) beat("rl.beat", i, 2'b01);
    rq_read_line = 2'b00;
    #1;
    check("rl.done.grant", 128'(rq_grant), 128'(2'b00));
    check("rl.done.addr", 128'(m_address), 128'(0));

    // Word write by requester 1, be=0011, data 0xBEEF
    rq_word_in_ready = 2'b10;
    rq_address[AW +: AW] = 14'h0123;
    rq_data_in[128 +: 128] = 128'h0000_BEEF;
    rq_word_in_be[4 +: 4] = 4'b0011;
    tick();
    check("ww.issue.grant", 128'(rq_grant), 128'(2'b10));
    check("ww.issue.wr", 128'(m_word_in_ready), 128'(1));
    check("ww.issue.rd", 128'(m_read_word), 128'(0));
    check("ww.issue.data", m_data_in, 128'h0000_BEEF);
    check("ww.issue.be", 128'(m_word_in_be), 128'(4'b0011));
    check("ww.issue.addr", 128'(m_address), 128'(14'h0123));
    tick();
    check("ww.busy.wr", 128'(m_word_in_ready), 128'(1));
    check("ww.busy.ready", 128'(rq_ready), 128'(2'b00));
    m_ready = 1'b1;
    #1;
    check("ww.beat.wr", 128'(m_word_in_ready), 128'(1));
    m_ready = 1'b0;
    beat("ww.beat", 0, 2'b10);
    rq_word_in_ready = 2'b00;
    #1;
    check("ww.done.wr", 128'(m_word_in_ready), 128'(0));
    check("ww.done.grant", 128'(rq_grant), 128'(2'b00));
    m_ready = 1'b1;  // ignored in IDLE
    #1;
    check("ww.idle.ignore", 128'(rq_ready), 128'(2'b00));
    m_ready = 1'b0;

    // Requester 0: read_word and line_in_ready together -> read_word only
    rq_read_word = 2'b01;
    rq_line_in_ready = 2'b01;
    rq_address[0 +: AW] = 14'h0300;
    tick();
    check("mix.issue.rdword", 128'(m_read_word), 128'(1));
    check("mix.issue.lwr", 128'(m_line_in_ready), 128'(0));
    check("mix.issue.rdline", 128'(m_read_line), 128'(0));
    tick();
    check("mix.busy.lwr", 128'(m_line_in_ready), 128'(0));
    beat("mix.beat", 0, 2'b01);
    rq_read_word = 2'b00;
    rq_line_in_ready = 2'b00;
    #1;
    check("mix.done.grant", 128'(rq_grant), 128'(2'b00));

    // Reset after second beat of a line read
    rq_read_line = 2'b01;
    rq_address[0 +: AW] = 14'h0080;
    tick();
    check("rr.issue.grant", 128'(rq_grant), 128'(2'b01));
    tick();
    beat("rr.beat", 0, 2'b01);
    beat("rr.beat", 1, 2'b01);
    reset = 1'b1;
    m_ready = 1'b1;
    #1;
    check("rr.rst.ready", 128'(rq_ready), 128'(2'b00));
    tick();
    reset = 1'b0;
    rq_read_line = 2'b00;
    #1;
    check("rr.after.grant", 128'(rq_grant), 128'(2'b00));
    check("rr.after.ready", 128'(rq_ready), 128'(2'b00));
    m_ready = 1'b0;
    rq_read_word = 2'b10;
    rq_address[AW +: AW] = 14'h0055;
    tick();
    check("rr.new.grant", 128'(rq_grant), 128'(2'b10));
    check("rr.new.rdword", 128'(m_read_word), 128'(1));
    check("rr.new.addr", 128'(m_address), 128'(14'h0055));
    tick();
    beat("rr.new.beat", 0, 2'b10);
    rq_read_word = 2'b00;
    #1;
    check("rr.new.done", 128'(rq_grant), 128'(2'b00));

    // Both requesters read_word continuously from a fresh reset
    clear_inputs();
    do_reset();
    rq_address[0 +: AW]  = 14'h0100;
    rq_address[AW +: AW] = 14'h0200;
    rq_read_word = 2'b11;
    #1;
    for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      exp_idx = 0;
`else
      exp_idx = k % 2;
`endif
      check("alt.idle.grant", 128'(rq_grant), 128'(2'b00));
      tick();
      check("alt.issue.grant", 128'(rq_grant), (exp_idx == 0) ? 128'(2'b01) : 128'(2'b10));
      check("alt.issue.addr", 128'(m_address), (exp_idx == 0) ? 128'(14'h0100) : 128'(14'h0200));
      check("alt.issue.rdword", 128'(m_read_word), 128'(1));
      tick();
      beat("alt.beat", 0, (exp_idx == 0) ? 2'b01 : 2'b10);
    end
    rq_read_word = 2'b00;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
